reg_block_transfer_ctrl: RTL and testbench



---
 rtl/reg_block_transfer_ctrl.sv | 144 ++++++++++++++
 tb/tb_reg_block_transfer_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_block_transfer_ctrl.sv
// Block load/store sequencer: walks a register mask lowest-first and issues one
// data-memory access per selected register, owning RF read port 2 / write port 3.
module reg_block_transfer_ctrl #(
  parameter int N_REGS     = 16,
  parameter int IDX_W      = 4,
  parameter int DATA_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic [N_REGS-1:0] reg_list,
  input  logic [DATA_W-1:0] base_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rf_rd_2,
  output logic [IDX_W-1:0]  rf_a_2,
  output logic [IDX_W-1:0]  rf_a_3,
  output logic              rf_we_3,
  output logic [DATA_W-1:0] rf_wd_3,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] final_addr,
  output logic              pc_loaded
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              r_state;
  logic [N_REGS-1:0]   r_list;
  logic                r_is_load;
  logic [DATA_W-1:0]   r_cur_addr;
  logic [DATA_W-1:0]   r_final_addr;
  logic                r_pc_loaded;
  logic                r_busy;
  logic                r_done;

  logic [DATA_W-1:0]   w_count;
  logic [DATA_W-1:0]   w_span;
  logic [N_REGS-1:0]   w_low_bit;
  logic [N_REGS-1:0]   w_list_after;
  logic [IDX_W-1:0]    w_idx;
  logic                w_access;
  logic                w_store;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < N_REGS; i++) begin
      w_count = w_count + DATA_W'(reg_list[i]);
    end
  end

  assign w_span = w_count * DATA_W'(WORD_BYTES);

  // Isolate the lowest remaining register; the list always drains in ascending order.
  assign w_low_bit    = r_list & (~r_list + N_REGS'(1));
  assign w_list_after = r_list & ~w_low_bit;

  always_comb begin
    w_idx = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (r_list[i]) begin
        w_idx = IDX_W'(i);
      end
    end
  end

  // Direction only matters for the start/final addresses, so 'up' is consumed at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_list       <= '0;
      r_is_load    <= 1'b0;
      r_cur_addr   <= '0;
      r_final_addr <= '0;
      r_pc_loaded  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_list       <= reg_list;
            r_is_load    <= is_load;
            r_pc_loaded  <= is_load & reg_list[N_REGS-1];
            r_cur_addr   <= up ? base_addr : base_addr - w_span;
            r_final_addr <= up ? base_addr + w_span : base_addr - w_span;
            if (w_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ACCESS;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            r_list     <= w_list_after;
            r_cur_addr <= r_cur_addr + DATA_W'(WORD_BYTES);
            if (w_list_after == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are masked by rst so nothing reaches memory or the RF in a reset cycle.
  assign w_access = (r_state == S_ACCESS) & ~rst;
  assign w_store  = w_access & ~r_is_load;

  assign mem_req    = w_access;
  assign mem_we     = w_store;
  assign mem_addr   = w_access ? r_cur_addr : '0;
  assign rf_a_2     = w_store ? w_idx : '0;
  assign mem_wdata  = w_store ? rf_rd_2 : '0;
  assign rf_we_3    = w_access & r_is_load & mem_ready;
  assign rf_a_3     = rf_we_3 ? w_idx : '0;
  assign rf_wd_3    = rf_we_3 ? mem_rdata : '0;
  assign busy       = r_busy;
  assign done       = r_done;
  assign final_addr = r_final_addr;
  assign pc_loaded  = r_done & r_pc_loaded;

endmodule

// File: tb/tb_reg_block_transfer_ctrl.sv
// Randomized bench for reg_block_transfer_ctrl against a list/address model and
// a bench-owned register file.
module tb_reg_block_transfer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        up;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] rf_rd_2;
  logic [3:0]  rf_a_2;
  logic [3:0]  rf_a_3;
  logic        rf_we_3;
  logic [31:0] rf_wd_3;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [31:0] final_addr;
  logic        pc_loaded;

  logic [31:0] tb_rf    [16];
  logic [31:0] init_val [16];
  logic [31:0] model_rf [16];
  logic        rf_preload;

  int n_cmp  = 0;
  int n_fail = 0;

  reg_block_transfer_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_load    (is_load),
    .up         (up),
    .reg_list   (reg_list),
    .base_addr  (base_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .rf_rd_2    (rf_rd_2),
    .rf_a_2     (rf_a_2),
    .rf_a_3     (rf_a_3),
    .rf_we_3    (rf_we_3),
    .rf_wd_3    (rf_wd_3),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .final_addr (final_addr),
    .pc_loaded  (pc_loaded)
  );

  always #5 clk = ~clk;

  assign rf_rd_2 = tb_rf[rf_a_2];

  always @(posedge clk) begin
    if (rf_preload) begin
      for (int i = 0; i < 16; i++) tb_rf[i] <= init_val[i];
    end else if (rf_we_3) begin
      tb_rf[rf_a_3] <= rf_wd_3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".mem_req"},   32'(mem_req),   32'h0);
    chk({tag, ".mem_we"},    32'(mem_we),    32'h0);
    chk({tag, ".mem_addr"},  mem_addr,       32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata,      32'h0);
    chk({tag, ".rf_a_2"},    32'(rf_a_2),    32'h0);
    chk({tag, ".rf_we_3"},   32'(rf_we_3),   32'h0);
    chk({tag, ".rf_a_3"},    32'(rf_a_3),    32'h0);
    chk({tag, ".rf_wd_3"},   rf_wd_3,        32'h0);
    chk({tag, ".busy"},      32'(busy),      32'h0);
    chk({tag, ".done"},      32'(done),      32'h0);
  endtask

  task automatic chk_rf(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s.R%0d", tag, i), tb_rf[i], model_rf[i]);
  endtask

  // waits < 0: random 0..2 wait cycles per access; abort_at >= 0: reset during that access.
  task automatic run_xfer(input string tag, input bit load, input bit upd,
                          input logic [15:0] list, input logic [31:0] base,
                          input int waits, input bit hold_start,
                          input int abort_at, input bit fixed_rd);
    int          idxq[$];
    int          n;
    int          w;
    logic [31:0] a0;
    logic [31:0] fin;
    logic [31:0] ea;
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) if (list[i]) idxq.push_back(i);
    n   = idxq.size();
    fin = upd ? base + 32'(4 * n) : base - 32'(4 * n);
    a0  = upd ? base : base - 32'(4 * n);

    @(negedge clk);
    start = 1'b1; is_load = load; up = upd; reg_list = list; base_addr = base;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    #1;
    chk({tag, ".accept.busy"},    32'(busy),    32'h0);
    chk({tag, ".accept.mem_req"}, 32'(mem_req), 32'h0);

    for (int k = 0; k < n; k++) begin
      w  = (waits < 0) ? int'($urandom_range(2, 0)) : waits;
      ea = a0 + 32'(4 * k);
      for (int c = 0; c <= w; c++) begin
        @(negedge clk);
        start = hold_start; is_load = 1'($urandom); up = 1'($urandom);
        reg_list = 16'($urandom); base_addr = $urandom;
        if (k == abort_at) begin
          rst = 1'b1; mem_ready = 1'b1;
          #1;
          chk({tag, ".rst.rf_we_3"}, 32'(rf_we_3), 32'h0);
          chk({tag, ".rst.mem_req"}, 32'(mem_req), 32'h0);
          @(negedge clk);
          rst = 1'b0; start = 1'b0;
          #1;
          chk_quiet({tag, ".post_rst"});
          chk({tag, ".post_rst.final_addr"}, final_addr, 32'h0);
          chk({tag, ".post_rst.pc_loaded"}, 32'(pc_loaded), 32'h0);
          @(negedge clk);
          #1;
          chk_quiet({tag, ".post_rst2"});
          $display("xfer %s load=%0b up=%0b list=%h base=%h aborted at access %0d",
                   tag, load, upd, list, base, k);
          return;
        end
        mem_ready = (c == w);
        rd = fixed_rd ? 32'(k + 1) : $urandom;
        mem_rdata = rd;
        #1;
        chk({tag, ".acc.mem_req"},  32'(mem_req), 32'h1);
        chk({tag, ".acc.busy"},     32'(busy),    32'h1);
        chk({tag, ".acc.done"},     32'(done),    32'h0);
        chk({tag, ".acc.mem_addr"}, mem_addr,     ea);
        chk({tag, ".acc.mem_we"},   32'(mem_we),  32'(!load));
        chk({tag, ".acc.rf_we_3"},  32'(rf_we_3), 32'(load && (c == w)));
        if (!load) begin
          chk({tag, ".acc.rf_a_2"},    32'(rf_a_2), 32'(idxq[k]));
          chk({tag, ".acc.mem_wdata"}, mem_wdata,   model_rf[idxq[k]]);
        end else if (c == w) begin
          chk({tag, ".acc.rf_a_3"},  32'(rf_a_3), 32'(idxq[k]));
          chk({tag, ".acc.rf_wd_3"}, rf_wd_3,     rd);
          model_rf[idxq[k]] = rd;
        end else begin
          chk({tag, ".acc.rf_wd_3_idle"}, rf_wd_3, 32'h0);
        end
      end
    end

    @(negedge clk);
    start = hold_start; mem_ready = 1'($urandom);
    #1;
    chk({tag, ".done"},            32'(done),      32'h1);
    chk({tag, ".done.busy"},       32'(busy),      32'h0);
    chk({tag, ".done.mem_req"},    32'(mem_req),   32'h0);
    chk({tag, ".done.rf_we_3"},    32'(rf_we_3),   32'h0);
    chk({tag, ".done.final_addr"}, final_addr,     fin);
    chk({tag, ".done.pc_loaded"},  32'(pc_loaded), 32'(load & list[15]));
    @(negedge clk);
    start = 1'b0;
    #1;
    chk_quiet({tag, ".after_done"});
    $display("xfer %s load=%0b up=%0b list=%h base=%h n=%0d final=%h",
             tag, load, upd, list, base, n, fin);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; reg_list = '0;
    base_addr = '0; mem_ready = 1'b0; mem_rdata = '0; rf_preload = 1'b1;
    for (int i = 0; i < 16; i++) init_val[i] = $urandom;
    init_val[1] = 32'hAAAA_AAAA;
    init_val[2] = 32'h0000_0005;
    for (int i = 0; i < 16; i++) model_rf[i] = init_val[i];

    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk_quiet("reset");
    chk("reset.final_addr", final_addr, 32'h0);
    chk("reset.pc_loaded", 32'(pc_loaded), 32'h0);
    @(negedge clk);
    rst = 1'b0; rf_preload = 1'b0;
    #1;
    chk_quiet("reset_next");

    run_xfer("store_dec", 1'b0, 1'b0, 16'h0006, 32'h200, 0, 1'b0, -1, 1'b0);
    chk_rf("store_dec");
    run_xfer("load_inc", 1'b1, 1'b1, 16'h0003, 32'h100, 0, 1'b0, -1, 1'b1);
    chk_rf("load_inc");
    run_xfer("wait3", 1'b1, 1'b1, 16'h0001, 32'h300, 3, 1'b0, -1, 1'b0);
    chk_rf("wait3");
    run_xfer("empty", 1'b1, 1'b1, 16'h0000, 32'h40, 0, 1'b0, -1, 1'b0);
    run_xfer("abort", 1'b1, 1'b1, 16'h00F0, 32'h500, 0, 1'b0, 2, 1'b0);
    chk_rf("abort");
    run_xfer("after_abort", 1'b1, 1'b0, 16'h00F0, 32'h600, 0, 1'b0, -1, 1'b0);
    chk_rf("after_abort");
    run_xfer("r15_overlap", 1'b1, 1'b1, 16'h8000, 32'h700, 0, 1'b1, -1, 1'b0);
    chk_rf("r15_overlap");
    run_xfer("wrap_dec", 1'b0, 1'b0, 16'h0007, 32'h4, -1, 1'b0, -1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] rl;
      rl = ($urandom_range(3, 0) == 0) ? 16'h0 : 16'($urandom);
      run_xfer($sformatf("rand%0d", t), 1'($urandom), 1'($urandom), rl, $urandom,
               -1, 1'($urandom), -1, 1'b0);
    end
    chk_rf("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
